segment_scanner: RTL

Parametrised time-multiplexing scan generator for multi-digit seven-segment displays, sitting between the display-data path and the anode/cathode drivers. It divides the board clock into a configurable per-digit dwell period and walks a digit index over a non-power-of-two digit count. It skips digits disabled by a runtime mask and inserts a blanking interval at each digit switch to suppress ghosting. It also emits a one-cycle tick per digit advance for downstream data latching.

---
 rtl/segment_pkg.sv | 16 +
 rtl/segment_next_digit.sv | 35 +++
 rtl/segment_scanner.sv | 86 ++++++++
 3 files changed

// File: rtl/segment_pkg.sv
// Shared defaults and width helper for the seven-segment scan generator.
package segment_pkg;

  localparam int DEF_NUM_DIGITS     = 8;
  localparam int DEF_DWELL_CYCLES   = 14637;
  localparam int DEF_BLANK_CYCLES   = 64;
  localparam bit DEF_SEL_ACTIVE_LOW = 1'b1;

  // Register width able to hold 0..n-1, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/segment_next_digit.sv
// Rotate-priority search: the first enabled digit after idx, wrapping past
// the last digit back to 0. Holds idx when no other digit is enabled.
module segment_next_digit
  import segment_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  localparam int IW = min1_clog2(NUM_DIGITS)
) (
  input  logic [IW-1:0]         idx_i,
  input  logic [NUM_DIGITS-1:0] mask_i,
  output logic [IW-1:0]         next_o
);

  int            pos;
  logic [IW-1:0] cand;
  logic          found;

  // Walk idx+1 .. idx+NUM_DIGITS-1 (mod NUM_DIGITS) and keep the first hit.
  always_comb begin
    next_o = idx_i;
    found  = 1'b0;
    pos    = 0;
    cand   = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      pos = int'(idx_i) + k;
      if (pos >= NUM_DIGITS) pos = pos - NUM_DIGITS;
      cand = IW'(pos);
      if (!found && mask_i[cand]) begin
        next_o = cand;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/segment_scanner.sv
// Time-multiplexing scan generator for multi-digit seven-segment displays.
// A slot counter divides the clock into per-digit dwell periods, the first
// BLANK_CYCLES of each slot are dark to suppress ghosting, and the digit
// index rotates over the digits enabled in digit_mask.
module segment_scanner
  import segment_pkg::*;
#(
  parameter int NUM_DIGITS     = DEF_NUM_DIGITS,
  parameter int DWELL_CYCLES   = DEF_DWELL_CYCLES,
  parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter bit SEL_ACTIVE_LOW = DEF_SEL_ACTIVE_LOW,
  localparam int IW = min1_clog2(NUM_DIGITS),
  localparam int CW = min1_clog2(DWELL_CYCLES)
) (
  input  logic                  Origin_Clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [IW-1:0]         digit_index,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  blank,
  output logic                  tick
);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         idx_next;
  logic                  slot_last;
  logic                  past_blank;
  logic                  drive;
  logic [NUM_DIGITS-1:0] sel_hot;

  segment_next_digit #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_next (
    .idx_i  (idx_q),
    .mask_i (digit_mask),
    .next_o (idx_next)
  );

  assign slot_last = (cnt_q == CW'(DWELL_CYCLES - 1));

  // With no blanking every cycle of the slot is driven.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign past_blank = 1'b1;
  end else begin : g_blank
    assign past_blank = (cnt_q >= CW'(BLANK_CYCLES));
  end

  // Next state: count through the slot while enabled, advance the digit on wrap.
  always_comb begin
    cnt_d = '0;
    idx_d = idx_q;
    if (enable) begin
      if (slot_last) begin
        cnt_d = '0;
        idx_d = idx_next;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Slot counter and digit index; reset parks on digit 0 at slot start.
  always_ff @(posedge Origin_Clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Output decode; reset is folded in so outputs go dark without a clock edge.
  always_comb begin
    drive   = ~reset & enable & past_blank & digit_mask[idx_q];
    sel_hot = '0;
    if (drive) sel_hot[idx_q] = 1'b1;
    digit_sel   = SEL_ACTIVE_LOW ? ~sel_hot : sel_hot;
    blank       = ~drive;
    tick        = ~reset & enable & slot_last;
    digit_index = idx_q;
  end

endmodule
